// File: rtl/accum_burst_source_if.sv
// Bundle between the burst source, its PS-side control registers and the accumulator.
// The master modport is the burst source; the slave modport is the control/accumulator side.
interface accum_burst_source_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
);
  logic              i_start;
  logic [DATA_W-1:0] i_base;
  logic [DATA_W-1:0] i_step;
  logic [LEN_W-1:0]  i_len;
  logic [DATA_W-1:0] i_result;
  logic              i_result_valid;
  logic              i_intr;
  logic [DATA_W-1:0] o_data;
  logic              o_data_valid;
  logic              o_busy;
  logic              o_done;
  logic [DATA_W-1:0] o_result;
  logic              o_match;
  logic              o_timeout;

  modport master (
    input  i_start, i_base, i_step, i_len, i_result, i_result_valid, i_intr,
    output o_data, o_data_valid, o_busy, o_done, o_result, o_match, o_timeout
  );

  modport slave (
    output i_start, i_base, i_step, i_len, i_result, i_result_valid, i_intr,
    input  o_data, o_data_valid, o_busy, o_done, o_result, o_match, o_timeout
  );
endinterface

// File: rtl/accum_burst_source.sv
// Burst source for the running-sum accumulator: emits an arithmetic sequence, tracks the
// expected sum, captures the accumulator's answer and reports done/match/timeout.
module accum_burst_source #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned WAIT_MAX = 64
) (
  input logic                  i_clk,
  input logic                  i_rst,
  accum_burst_source_if.master bus
);

  localparam int unsigned WCNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              seen_q, seen_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              match_q, match_d;
  logic              timeout_q, timeout_d;

  // State register; synchronous active-low reset clears everything.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= StIdle;
      data_q    <= '0;
      valid_q   <= 1'b0;
      step_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      exp_q     <= '0;
      wcnt_q    <= '0;
      seen_q    <= 1'b0;
      result_q  <= '0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      step_q    <= step_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      exp_q     <= exp_d;
      wcnt_q    <= wcnt_d;
      seen_q    <= seen_d;
      result_q  <= result_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: burst generation, expected-sum tracking and result capture.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    step_d    = step_q;
    len_d     = len_q;
    idx_d     = idx_q;
    exp_d     = exp_q;
    wcnt_d    = wcnt_q;
    seen_d    = seen_q;
    result_d  = result_q;
    match_d   = match_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          step_d    = bus.i_step;
          len_d     = bus.i_len;
          idx_d     = '0;
          exp_d     = '0;
          wcnt_d    = '0;
          seen_d    = 1'b0;
          result_d  = '0;
          match_d   = 1'b0;
          timeout_d = 1'b0;
          if (bus.i_len != '0) begin
            // First word is registered here so it is on the bus the cycle after start.
            state_d = StSend;
            data_d  = bus.i_base;
            valid_d = 1'b1;
          end else begin
            // Empty burst: captured 0 trivially equals expected 0.
            state_d = StDone;
            match_d = 1'b1;
          end
        end
      end
      StSend: begin
        exp_d = exp_q + data_q;
        if (idx_q == len_q - LEN_W'(1)) begin
          state_d = StWait;
          valid_d = 1'b0;
          data_d  = '0;
        end else begin
          idx_d  = idx_q + LEN_W'(1);
          data_d = data_q + step_q;
        end
      end
      StWait: begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        if (bus.i_result_valid) begin
          result_d = bus.i_result;
          seen_d   = 1'b1;
        end
        // intr is only meaningful once a result has been seen; the accumulator idles with it high.
        if (seen_q && bus.i_intr && !bus.i_result_valid) begin
          state_d = StDone;
          match_d = (result_q == exp_q);
        end else if (wcnt_d == WCNT_W'(WAIT_MAX)) begin
          state_d   = StDone;
          timeout_d = 1'b1;
          match_d   = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_busy       = (state_q == StSend) || (state_q == StWait);
  assign bus.o_done       = (state_q == StDone);
  assign bus.o_result     = result_q;
  assign bus.o_match      = match_q;
  assign bus.o_timeout    = timeout_q;

endmodule

// File: tb/tb_accum_burst_source.sv
// Bench for accum_burst_source: directed and random bursts against a behavioural accumulator
// and an arithmetic reference for words, sums, latency and status.
module tb_accum_burst_source;

  localparam int WAIT_MAX = 64;

  logic clk;
  logic rst_n;

  accum_burst_source_if #(.DATA_W(32), .LEN_W(16)) bus ();

  accum_burst_source #(
    .DATA_W  (32),
    .LEN_W   (16),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Accumulator model controls.
  bit          acc_silent = 1'b0;
  logic [31:0] acc_off    = '0;
  logic [31:0] acc_sum;
  logic [31:0] m_res;
  logic        m_rv;
  logic        m_intr;

  assign bus.i_result       = m_res;
  assign bus.i_result_valid = m_rv;
  assign bus.i_intr         = m_intr;

  // One-cycle running-sum accumulator; intr idles high, drops while words arrive.
  always @(posedge clk) begin
    logic [31:0] nsum;
    if (!rst_n) begin
      acc_sum <= '0;
      m_res   <= '0;
      m_rv    <= 1'b0;
      m_intr  <= 1'b1;
    end else if (acc_silent) begin
      m_rv   <= 1'b0;
      m_intr <= 1'b1;
    end else if (bus.o_data_valid) begin
      nsum    = (m_intr ? 32'd0 : acc_sum) + bus.o_data;
      acc_sum <= nsum;
      m_res   <= nsum + acc_off;
      m_rv    <= 1'b1;
      m_intr  <= 1'b0;
    end else if (m_rv) begin
      m_rv   <= 1'b0;
      m_intr <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Run one burst and compare everything observed against the reference.
  task automatic run_burst(input string tag, input logic [31:0] b, input logic [31:0] s,
                           input logic [15:0] l, input bit silent, input logic [31:0] off,
                           input int restart);
    logic [31:0] words[$];
    logic [31:0] exp_sum, exp_res, exp_w;
    logic [31:0] res_done;
    logic        match_done, to_done;
    bit          exp_match, exp_to;
    int          ndone, nbusy, done_at, exp_lat, exp_busy, budget;

    @(negedge clk);
    acc_silent  = silent;
    acc_off     = off;
    bus.i_base  = b;
    bus.i_step  = s;
    bus.i_len   = l;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;

    check_eq({tag, " start_timeout"}, 64'(bus.o_timeout), 64'(0));
    check_eq({tag, " start_result"}, 64'(bus.o_result), 64'(0));
    check_eq({tag, " start_busy"}, 64'(bus.o_busy), 64'(l != 0));
    check_eq({tag, " start_match"}, 64'(bus.o_match), 64'(l == 0));

    ndone = 0; nbusy = 0; done_at = -1;
    res_done = '0; match_done = 1'b0; to_done = 1'b0;
    budget = int'(l) + WAIT_MAX + 10;
    for (int c = 0; c < budget; c++) begin
      if (c > 0) @(negedge clk);
      bus.i_start = (c == restart);
      if (bus.o_data_valid) words.push_back(bus.o_data);
      if (bus.o_busy) nbusy++;
      if (bus.o_done) begin
        ndone++;
        if (done_at < 0) begin
          done_at    = c;
          res_done   = bus.o_result;
          match_done = bus.o_match;
          to_done    = bus.o_timeout;
        end
      end
      if (done_at >= 0 && c >= done_at + 3) break;
    end
    bus.i_start = 1'b0;

    exp_sum = '0;
    for (int k = 0; k < int'(l); k++) exp_sum += b + s * 32'(k);
    exp_to    = silent && (l != 0);
    exp_res   = (l == 0) ? 32'd0 : (silent ? 32'd0 : exp_sum + off);
    exp_match = (l == 0) || (!silent && off == 0);
    exp_lat   = (l == 0) ? 0 : (silent ? int'(l) + WAIT_MAX : int'(l) + 2);
    exp_busy  = exp_lat;

    check_eq({tag, " nwords"}, 64'(words.size()), 64'(l));
    for (int k = 0; k < words.size() && k < int'(l); k++) begin
      exp_w = b + s * 32'(k);
      check_eq($sformatf("%s word%0d", tag, k), 64'(words[k]), 64'(exp_w));
    end
    check_eq({tag, " done_seen"}, 64'(done_at >= 0), 64'(1));
    check_eq({tag, " done_count"}, 64'(ndone), 64'(1));
    check_eq({tag, " done_latency"}, 64'(done_at), 64'(exp_lat));
    check_eq({tag, " busy_cycles"}, 64'(nbusy), 64'(exp_busy));
    check_eq({tag, " result"}, 64'(res_done), 64'(exp_res));
    check_eq({tag, " match"}, 64'(match_done), 64'(exp_match));
    check_eq({tag, " timeout"}, 64'(to_done), 64'(exp_to));
    check_eq({tag, " result_hold"}, 64'(bus.o_result), 64'(exp_res));
    check_eq({tag, " match_hold"}, 64'(bus.o_match), 64'(exp_match));
    check_eq({tag, " timeout_hold"}, 64'(bus.o_timeout), 64'(exp_to));
  endtask

  initial begin
    logic [31:0] rb, rs, roff;
    logic [15:0] rl;
    bit          rsil;
    int          ndone;

    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_base  = '0;
    bus.i_step  = '0;
    bus.i_len   = '0;
    repeat (3) @(negedge clk);
    check_eq("reset data", 64'(bus.o_data), 64'(0));
    check_eq("reset valid", 64'(bus.o_data_valid), 64'(0));
    check_eq("reset busy", 64'(bus.o_busy), 64'(0));
    check_eq("reset done", 64'(bus.o_done), 64'(0));
    check_eq("reset result", 64'(bus.o_result), 64'(0));
    check_eq("reset match", 64'(bus.o_match), 64'(0));
    check_eq("reset timeout", 64'(bus.o_timeout), 64'(0));
    rst_n = 1'b1;

    run_burst("inc4", 32'd1, 32'd1, 16'd4, 1'b0, 32'd0, -1);
    run_burst("wrap3", 32'hFFFF_FFFF, 32'd1, 16'd3, 1'b0, 32'd0, -1);
    run_burst("len0", 32'd7, 32'd9, 16'd0, 1'b0, 32'd0, -1);
    run_burst("timeout", 32'd3, 32'd4, 16'd5, 1'b1, 32'd0, -1);
    run_burst("after_to", 32'd10, 32'd10, 16'd2, 1'b0, 32'd0, -1);
    run_burst("corrupt", 32'd5, 32'd2, 16'd3, 1'b0, 32'hFFFF_FFFF, -1);
    run_burst("restart", 32'd100, 32'd3, 16'd8, 1'b0, 32'd0, 2);

    // Reset asserted while word 2 of an 8-word burst is on the bus.
    @(negedge clk);
    acc_silent  = 1'b0;
    acc_off     = '0;
    bus.i_base  = 32'd100;
    bus.i_step  = 32'd3;
    bus.i_len   = 16'd8;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst word2", 64'(bus.o_data), 64'(106));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst valid", 64'(bus.o_data_valid), 64'(0));
    check_eq("rst busy", 64'(bus.o_busy), 64'(0));
    check_eq("rst data", 64'(bus.o_data), 64'(0));
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.o_done || bus.o_data_valid || bus.o_busy) ndone++;
    end
    check_eq("rst quiet", 64'(ndone), 64'(0));

    for (int i = 0; i < 12; i++) begin
      rb   = $urandom;
      rs   = $urandom;
      rl   = 16'($urandom_range(1, 40));
      if ($urandom_range(0, 7) == 0) rl = '0;
      rsil = ($urandom_range(0, 9) == 0);
      roff = ($urandom_range(0, 3) == 0) ? ($urandom | 32'd1) : 32'd0;
      run_burst($sformatf("rand%0d", i), rb, rs, rl, rsil, roff, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
